// File: rtl/cam_pkg.sv
// Shared types and defaults for the OV7670 capture front end.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_FRAME,
        LINE_IDLE,
        BYTE_LO
    } cap_state_e;

    // Camera bus bundled so every bit rides the same synchronizer depth.
    typedef struct packed {
        logic       pclk;
        logic       href;
        logic       vsync;
        logic [7:0] data;
    } cam_bus_t;

endpackage

// File: rtl/ov7670_capture_if.sv
// Pixel stream from the capture block toward the frame buffer / edge pipeline.
interface ov7670_capture_if;
    import cam_pkg::*;

    logic       pixel_valid;
    rgb565_t    pixel_data;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic       frame_start;
    logic       frame_done;
    logic       line_err;

    modport master (
        output pixel_valid, pixel_data, pixel_x, pixel_y,
               frame_start, frame_done, line_err
    );

    modport slave (
        input pixel_valid, pixel_data, pixel_x, pixel_y,
              frame_start, frame_done, line_err
    );

endinterface

// File: rtl/cam_sync.sv
// Multi-bit bus synchronizer: every bit sees the same STAGES-deep flop chain.
module cam_sync #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff[0] <= din;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign dout = ff[STAGES-1];

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 parallel capture: oversampled PCLK edge detect, RGB565 assembly,
// x/y tagging and frame markers, all in the 125 MHz domain.
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_125mhz,
    input  logic               reset,
    input  logic               capture_en,
    input  logic               cam_pclk,
    input  logic               cam_href,
    input  logic               cam_vsync,
    input  logic [7:0]         cam_data,
    ov7670_capture_if.master   pix
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE);
    localparam logic [8:0] Y_MAX = 9'(V_ACTIVE);

    cam_bus_t   s_bus;
    cam_bus_t   d1;
    logic       pclk_d2, href_d2, vsync_d2;

    logic       ev_rise, ev_href, ev_href_fall;
    logic       ev_vs, ev_vs_rise, ev_vs_fall;
    logic [7:0] ev_data;

    cap_state_e state;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] hi;

    cam_sync #(
        .WIDTH ($bits(cam_bus_t)),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk_125mhz),
        .reset(reset),
        .din  ({cam_pclk, cam_href, cam_vsync, cam_data}),
        .dout (s_bus)
    );

    // Edges and the byte/href sampled with them are registered together so
    // the FSM sees a clean, aligned event word.
    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            d1           <= '0;
            pclk_d2      <= 1'b0;
            href_d2      <= 1'b0;
            vsync_d2     <= 1'b0;
            ev_rise      <= 1'b0;
            ev_href      <= 1'b0;
            ev_href_fall <= 1'b0;
            ev_vs        <= 1'b0;
            ev_vs_rise   <= 1'b0;
            ev_vs_fall   <= 1'b0;
            ev_data      <= '0;
        end else begin
            d1           <= s_bus;
            pclk_d2      <= d1.pclk;
            href_d2      <= d1.href;
            vsync_d2     <= d1.vsync;
            ev_rise      <= d1.pclk & ~pclk_d2;
            ev_href      <= d1.href;
            ev_href_fall <= href_d2 & ~d1.href;
            ev_vs        <= d1.vsync;
            ev_vs_rise   <= d1.vsync & ~vsync_d2;
            ev_vs_fall   <= vsync_d2 & ~d1.vsync;
            ev_data      <= d1.data;
        end
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            state           <= WAIT_VS;
            x               <= '0;
            y               <= '0;
            hi              <= '0;
            pix.pixel_valid <= 1'b0;
            pix.pixel_data  <= '0;
            pix.pixel_x     <= '0;
            pix.pixel_y     <= '0;
            pix.frame_start <= 1'b0;
            pix.frame_done  <= 1'b0;
            pix.line_err    <= 1'b0;
        end else begin
            pix.pixel_valid <= 1'b0;
            pix.frame_start <= 1'b0;
            pix.frame_done  <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (ev_vs) state <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (ev_vs_fall && capture_en) begin
                        pix.frame_start <= 1'b1;
                        pix.line_err    <= 1'b0;
                        x               <= '0;
                        y               <= '0;
                        state           <= LINE_IDLE;
                    end
                end
                LINE_IDLE, BYTE_LO: begin
                    // vsync outranks a coincident PCLK edge; that byte is lost.
                    if (ev_vs_rise) begin
                        pix.frame_done <= 1'b1;
                        if (y != Y_MAX) pix.line_err <= 1'b1;
                        state <= WAIT_FRAME;
                    end else if (ev_href_fall) begin
                        x <= '0;
                        if (y != Y_MAX) y <= y + 9'd1;
                        if (state == BYTE_LO) pix.line_err <= 1'b1;
                        state <= LINE_IDLE;
                    end else if (ev_rise && ev_href) begin
                        if (state == LINE_IDLE) begin
                            hi    <= ev_data;
                            state <= BYTE_LO;
                        end else begin
                            state <= LINE_IDLE;
                            if (y == Y_MAX || x == X_MAX) begin
                                pix.line_err <= 1'b1;
                            end else begin
                                pix.pixel_valid <= 1'b1;
                                pix.pixel_data  <= {hi, ev_data};
                                pix.pixel_x     <= x;
                                pix.pixel_y     <= y;
                                x               <= x + 10'd1;
                            end
                        end
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized camera-stream bench for ov7670_capture with a line/frame level model.
module tb_ov7670_capture;

    localparam int H_T = 4;
    localparam int V_T = 4;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        int          t;
    } exp_t;

    logic       clk_125mhz = 1'b0;
    logic       reset;
    logic       capture_en;
    logic       cam_pclk, cam_href, cam_vsync;
    logic [7:0] cam_data;

    ov7670_capture_if pix ();

    ov7670_capture #(
        .H_ACTIVE   (H_T),
        .V_ACTIVE   (V_T),
        .SYNC_STAGES(2)
    ) dut (
        .clk_125mhz(clk_125mhz),
        .reset     (reset),
        .capture_en(capture_en),
        .cam_pclk  (cam_pclk),
        .cam_href  (cam_href),
        .cam_vsync (cam_vsync),
        .cam_data  (cam_data),
        .pix       (pix)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    int   cyc = 0;
    int   checks = 0, fails = 0;
    int   fs_cnt = 0, fd_cnt = 0, pv_cnt = 0;
    int   exp_fs = 0, exp_fd = 0, exp_pv = 0;
    bit   exp_err = 0;
    bit   armed = 0, captured = 0, fix_first = 0;
    exp_t q[$];

    always @(posedge clk_125mhz) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk_125mhz) begin
        exp_t e;
        if (pix.pixel_valid === 1'b1) begin
            pv_cnt++;
            chk("pixel_expected", (q.size() > 0) ? 64'd1 : 64'd0, 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pixel_dxy", {pix.pixel_data, pix.pixel_x, pix.pixel_y}, {e.d, e.x, e.y});
                chk("pixel_latency", cyc, e.t);
            end
        end
        if (pix.frame_start === 1'b1) fs_cnt++;
        if (pix.frame_done === 1'b1) fd_cnt++;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, pix.pixel_valid, 0);
        chk({tag, "_data"},  pix.pixel_data, 0);
        chk({tag, "_x"},     pix.pixel_x, 0);
        chk({tag, "_y"},     pix.pixel_y, 0);
        chk({tag, "_fs"},    pix.frame_start, 0);
        chk({tag, "_fd"},    pix.frame_done, 0);
        chk({tag, "_err"},   pix.line_err, 0);
    endtask

    // One href-high line of n bytes; the model records which pixels must appear.
    task automatic send_line(input int n, input int ly);
        logic [7:0] b, hi;
        hi = '0;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (fix_first && ly == 0 && i < 2) b = (i == 0) ? 8'h12 : 8'h34;
            @(negedge clk_125mhz);
            cam_pclk = 1'b0; cam_data = b; cam_href = 1'b1;
            repeat ($urandom_range(2, 3)) @(negedge clk_125mhz);
            cam_pclk = 1'b1;
            if (i % 2 == 1 && captured && ly < V_T && i / 2 < H_T) begin
                q.push_back('{d: {hi, b}, x: 10'(i / 2), y: 9'(ly), t: cyc + 5});
                exp_pv++;
            end
            if (i % 2 == 0) hi = b;
            repeat ($urandom_range(2, 3)) @(negedge clk_125mhz);
        end
        @(negedge clk_125mhz);
        cam_pclk = 1'b0; cam_href = 1'b0;
        repeat (4) @(negedge clk_125mhz);
        if (captured && ((n % 2 == 1) || (n / 2 > H_T) || (ly >= V_T && n > 0))) exp_err = 1;
    endtask

    task automatic vs_fall_start();
        @(negedge clk_125mhz);
        cam_vsync = 1'b1; armed = 1;
        repeat ($urandom_range(6, 12)) @(negedge clk_125mhz);
        cam_vsync = 1'b0;
        captured = armed && capture_en;
        if (captured) begin
            exp_fs++;
            exp_err = 0;
        end
        repeat (8) @(negedge clk_125mhz);
        chk("frame_start_cnt", fs_cnt, exp_fs);
        if (captured) chk("err_cleared", pix.line_err, 0);
    endtask

    task automatic frame(input int nlines, input int nbytes, input int sp_line,
                         input int sp_n, input int en_after1);
        vs_fall_start();
        for (int l = 0; l < nlines; l++) begin
            send_line((l == sp_line) ? sp_n : nbytes, l);
            if (l == 1 && en_after1 >= 0) capture_en = en_after1[0];
        end
        repeat (4) @(negedge clk_125mhz);
        cam_vsync = 1'b1;
        if (captured) begin
            exp_fd++;
            if (nlines < V_T) exp_err = 1;
        end
        repeat (8) @(negedge clk_125mhz);
        chk("frame_done_cnt", fd_cnt, exp_fd);
        chk("line_err", pix.line_err, exp_err);
        chk("pixel_count", pv_cnt, exp_pv);
    endtask

    initial begin
        reset = 1'b1; capture_en = 1'b1;
        cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0; cam_data = '0;
        repeat (5) @(negedge clk_125mhz);
        check_zero("reset");
        reset = 1'b0;

        // href activity with vsync held low: nothing may be captured
        send_line(8, 0);
        send_line(8, 1);
        chk("no_start_before_vs", fs_cnt, 0);
        chk("no_pixels_before_vs", pv_cnt, 0);

        fix_first = 1;
        frame(4, 8, -1, 0, -1);
        fix_first = 0;

        frame(4, 8, 2, 7, -1);          // odd byte count
        frame(4, 8, -1, 0, -1);         // error clears at next start
        frame(4, 8, 1, 12, -1);         // overrun: 6 pixels into 4 columns
        frame(3, 8, -1, 0, -1);         // short frame
        frame(4, 2 * $urandom_range(1, 4), -1, 0, -1);
        frame(5, 2 * $urandom_range(1, 4), -1, 0, -1);   // extra line past V_ACTIVE

        frame(4, 8, -1, 0, 0);          // enable drops mid-frame
        frame(4, 8, -1, 0, -1);         // not captured
        capture_en = 1'b1;
        frame(4, 8, -1, 0, -1);

        // reset during line 2 of a captured frame
        vs_fall_start();
        send_line(8, 0);
        send_line(8, 1);
        @(negedge clk_125mhz);
        cam_pclk = 1'b0; cam_data = 8'h5a; cam_href = 1'b1;
        repeat (3) @(negedge clk_125mhz);
        cam_pclk = 1'b1;
        repeat (3) @(negedge clk_125mhz);
        reset = 1'b1;
        @(negedge clk_125mhz);
        check_zero("midreset");
        reset = 1'b0;
        armed = 0; captured = 0; exp_err = 0;
        send_line(6, 2);
        send_line(8, 3);
        @(negedge clk_125mhz);
        cam_vsync = 1'b1; armed = 1;
        repeat (10) @(negedge clk_125mhz);
        chk("no_done_after_reset", fd_cnt, exp_fd);
        frame(4, 8, -1, 0, -1);

        repeat (20) @(negedge clk_125mhz);
        chk("pending_pixels", q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
